priority_queue_sync: RTL and testbench

Clocked, parametrised priority queue holding up to DEPTH entries of WIDTH bits, kept sorted so the highest-priority entry is always presented at the head. It is the synchronous successor to the team's unclocked priority queue. It adds a clock, a configurable min/max ordering, full/empty/count status, simultaneous enqueue+dequeue, and error pulses. It sits between producers of tagged work items and a single consumer that always takes the best item.

---
 rtl/priority_queue_sync_pkg.sv | 24 ++
 rtl/priority_queue_sync_if.sv | 31 +++
 rtl/priority_queue_sync_slot.sv | 65 ++++++
 rtl/priority_queue_sync.sv | 117 +++++++++++
 tb/tb_priority_queue_sync.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/priority_queue_sync_pkg.sv
// Shared constants, op decode type and priority compare
// for the clocked priority queue.
package pq_pkg;

    localparam int PQ_MIN_FIRST = 0;
    localparam int PQ_MAX_FIRST = 1;
    localparam int PQ_KEY_W     = 32;

    typedef enum logic [1:0] {
        OP_HOLD,
        OP_ENQ,
        OP_DEQ,
        OP_BOTH
    } pq_op_t;

    function automatic logic higher_prio(
        input logic [PQ_KEY_W-1:0] a,
        input logic [PQ_KEY_W-1:0] b,
        input logic                mode
    );
        return mode ? (a > b) : (a < b);
    endfunction

endpackage

// File: rtl/priority_queue_sync_if.sv
// Producer/consumer bundle of the priority queue.
// master drives requests, slave is the queue.
interface priority_queue_sync_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             enqueue_sig;
    logic             dequeue_sig;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             empty;
    logic             full;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output enqueue_sig, dequeue_sig, data_in,
        input  data_out, empty, full, count,
        input  overflow, underflow
    );

    modport slave (
        input  enqueue_sig, dequeue_sig, data_in,
        output data_out, empty, full, count,
        output overflow, underflow
    );

endinterface

// File: rtl/priority_queue_sync_slot.sv
// One storage slot: own compare plus a four-way
// next-value select (hold / data_in / upper / lower).
module pq_slot
    import pq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int MODE  = PQ_MIN_FIRST,
    parameter bit HEAD  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  pq_op_t           i_op,
    input  logic [WIDTH-1:0] i_data,
    input  logic [WIDTH-1:0] i_upper,
    input  logic [WIDTH-1:0] i_lower,
    input  logic             i_valid,
    input  logic             i_cmp_upper,
    input  logic             i_cmp_lower,
    output logic [WIDTH-1:0] o_entry,
    output logic             o_cmp
);

    logic [WIDTH-1:0] r_entry;
    logic [WIDTH-1:0] w_next;
    logic             w_cmp;

    // An empty slot counts as beaten, so the insertion
    // point is always the first slot with w_cmp set.
    assign w_cmp = !i_valid || higher_prio(
        PQ_KEY_W'(i_data), PQ_KEY_W'(r_entry),
        MODE == PQ_MAX_FIRST);

    always_comb begin
        w_next = r_entry;
        unique case (i_op)
            OP_ENQ: begin
                if (w_cmp)
                    w_next = i_cmp_upper ? i_upper : i_data;
            end
            OP_DEQ: w_next = i_lower;
            // Head leaves: slots before the new insertion
            // point pull up, slots after it keep their entry.
            OP_BOTH: begin
                if (!i_cmp_lower)
                    w_next = i_lower;
                else if (!HEAD && w_cmp)
                    w_next = r_entry;
                else
                    w_next = i_data;
            end
            default: w_next = r_entry;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_entry <= '0;
        else
            r_entry <= w_next;
    end

    assign o_entry = r_entry;
    assign o_cmp   = w_cmp;

endmodule

// File: rtl/priority_queue_sync.sv
// Sorted priority queue: slot array plus count,
// status flags and the enqueue/dequeue decode.
module priority_queue_sync
    import pq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int MODE  = PQ_MIN_FIRST
) (
    input logic                  clk,
    input logic                  rst,
    priority_queue_sync_if.slave bus
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0]    r_count;
    logic             r_empty;
    logic             r_full;
    logic             r_ovf;
    logic             r_udf;
    pq_op_t           w_op;
    logic             w_ovf;
    logic             w_udf;
    logic [CW-1:0]    w_cnt_nxt;
    logic [WIDTH-1:0] w_entry [DEPTH+1];
    logic             w_cmp   [DEPTH+1];
    logic [WIDTH-1:0] w_up    [DEPTH];
    logic             w_cup   [DEPTH];
    logic             w_enq;
    logic             w_deq;

    assign w_enq = bus.enqueue_sig;
    assign w_deq = bus.dequeue_sig;

    always_comb begin
        w_op  = OP_HOLD;
        w_ovf = 1'b0;
        w_udf = 1'b0;
        unique case (1'b1)
            (w_enq && w_deq && !r_empty): w_op = OP_BOTH;
            (w_enq && w_deq && r_empty): begin
                w_op  = OP_ENQ;
                w_udf = 1'b1;
            end
            (w_enq && !w_deq && !r_full): w_op = OP_ENQ;
            (w_enq && !w_deq && r_full): w_ovf = 1'b1;
            (!w_enq && w_deq && !r_empty): w_op = OP_DEQ;
            (!w_enq && w_deq && r_empty): w_udf = 1'b1;
            default: w_op = OP_HOLD;
        endcase
    end

    always_comb begin
        w_cnt_nxt = r_count;
        if (w_op == OP_ENQ)
            w_cnt_nxt = r_count + 1'b1;
        else if (w_op == OP_DEQ)
            w_cnt_nxt = r_count - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else begin
            r_count <= w_cnt_nxt;
            r_empty <= (w_cnt_nxt == '0);
            r_full  <= (w_cnt_nxt == CW'(DEPTH));
            r_ovf   <= w_ovf;
            r_udf   <= w_udf;
        end
    end

    // Beyond the tail: an always-beaten empty slot.
    assign w_entry[DEPTH] = '0;
    assign w_cmp[DEPTH]   = 1'b1;

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        if (g == 0) begin : g_head
            assign w_up[g]  = '0;
            assign w_cup[g] = 1'b0;
        end else begin : g_body
            assign w_up[g]  = w_entry[g-1];
            assign w_cup[g] = w_cmp[g-1];
        end

        pq_slot #(
            .WIDTH (WIDTH),
            .MODE  (MODE),
            .HEAD  (g == 0)
        ) u_slot (
            .clk         (clk),
            .rst         (rst),
            .i_op        (w_op),
            .i_data      (bus.data_in),
            .i_upper     (w_up[g]),
            .i_lower     (w_entry[g+1]),
            .i_valid     (CW'(g) < r_count),
            .i_cmp_upper (w_cup[g]),
            .i_cmp_lower (w_cmp[g+1]),
            .o_entry     (w_entry[g]),
            .o_cmp       (w_cmp[g])
        );
    end

    assign bus.data_out  = w_entry[0];
    assign bus.empty     = r_empty;
    assign bus.full      = r_full;
    assign bus.count     = r_count;
    assign bus.overflow  = r_ovf;
    assign bus.underflow = r_udf;

endmodule

// File: tb/tb_priority_queue_sync.sv
// Min-first and max-first queues under one stimulus,
// checked each cycle against a sorted-list model.
module tb_priority_queue_sync;

    localparam int W = 8;
    localparam int D = 8;

    typedef struct {
        int val;
        int tag;
    } ent_t;
    typedef ent_t ent_q_t[$];

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enq = 1'b0;
    logic       deq = 1'b0;
    logic [W-1:0] din = '0;
    bit         checking = 1'b0;

    int n_err = 0;
    int n_checks = 0;

    priority_queue_sync_if #(.WIDTH(W), .DEPTH(D)) bus0 ();
    priority_queue_sync_if #(.WIDTH(W), .DEPTH(D)) bus1 ();

    assign bus0.enqueue_sig = enq;
    assign bus0.dequeue_sig = deq;
    assign bus0.data_in     = din;
    assign bus1.enqueue_sig = enq;
    assign bus1.dequeue_sig = deq;
    assign bus1.data_in     = din;

    priority_queue_sync #(.WIDTH(W), .DEPTH(D), .MODE(0))
        dut0 (.clk(clk), .rst(rst), .bus(bus0));
    priority_queue_sync #(.WIDTH(W), .DEPTH(D), .MODE(1))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    ent_q_t mq0, mq1;
    ent_t   pop1[$];
    bit     eovf [2];
    bit     eudf [2];
    int     tag = 0;

    function automatic bit better(int a, int b, int mode);
        return (mode == 1) ? (a > b) : (a < b);
    endfunction

    function automatic ent_q_t ins(ent_q_t q, ent_t e,
                                   int mode);
        int pos = q.size();
        for (int i = q.size() - 1; i >= 0; i--)
            if (better(e.val, q[i].val, mode)) pos = i;
        q.insert(pos, e);
        return q;
    endfunction

    function automatic ent_q_t mstep(
        input ent_q_t q, input int mode,
        input bit e, input bit d, input int v,
        input int t, output bit ovf, output bit udf,
        output ent_t pe, output bit dp);
        ent_t ne;
        ne.val = v;
        ne.tag = t;
        ovf = 0;
        udf = 0;
        dp = 0;
        pe.val = 0;
        pe.tag = 0;
        if (d && q.size() > 0) begin
            pe = q.pop_front();
            dp = 1;
        end else if (d) begin
            udf = 1;
        end
        if (e) begin
            if (!d && q.size() >= D) ovf = 1;
            else q = ins(q, ne, mode);
        end
        return q;
    endfunction

    always @(posedge clk or posedge rst) begin
        ent_t pe;
        bit   dp;
        if (rst) begin
            mq0.delete();
            mq1.delete();
            pop1.delete();
            eovf[0] = 0; eovf[1] = 0;
            eudf[0] = 0; eudf[1] = 0;
        end else begin
            tag++;
            mq0 = mstep(mq0, 0, enq, deq, int'(din), tag,
                        eovf[0], eudf[0], pe, dp);
            mq1 = mstep(mq1, 1, enq, deq, int'(din), tag,
                        eovf[1], eudf[1], pe, dp);
            if (dp) pop1.push_back(pe);
        end
    end

    // ---------------- checking ----------------
    task automatic chk(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0d expected %0d",
                     name, $time, act, exp);
        end
    endtask

    task automatic cmp_dut(int m, int dout, int cnt,
                           bit emp, bit ful, bit ov, bit ud);
        int n = (m == 0) ? mq0.size() : mq1.size();
        int h = 0;
        if (n > 0) h = (m == 0) ? mq0[0].val : mq1[0].val;
        chk($sformatf("d%0d.data_out", m), dout, h);
        chk($sformatf("d%0d.count", m), cnt, n);
        chk($sformatf("d%0d.empty", m), int'(emp),
            int'(n == 0));
        chk($sformatf("d%0d.full", m), int'(ful),
            int'(n == D));
        chk($sformatf("d%0d.overflow", m), int'(ov),
            int'(eovf[m]));
        chk($sformatf("d%0d.underflow", m), int'(ud),
            int'(eudf[m]));
    endtask

    always @(negedge clk) begin
        if (checking && !rst) begin
            cmp_dut(0, int'(bus0.data_out), int'(bus0.count),
                    bus0.empty, bus0.full,
                    bus0.overflow, bus0.underflow);
            cmp_dut(1, int'(bus1.data_out), int'(bus1.count),
                    bus1.empty, bus1.full,
                    bus1.overflow, bus1.underflow);
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_op(bit e, bit d, int v);
        enq = e;
        deq = d;
        din = W'(v);
        @(posedge clk);
        #1;
        enq = 0;
        deq = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        #2;
        rst = 0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst.count", int'(bus0.count), 0);
        chk("rst.empty", int'(bus0.empty), 1);
        chk("rst.full", int'(bus0.full), 0);
        chk("rst.data_out", int'(bus0.data_out), 0);
        chk("rst.ovf", int'(bus0.overflow), 0);
        chk("rst.udf", int'(bus0.underflow), 0);
        rst = 0;
        checking = 1;
        @(posedge clk);
        #1;

        // min-first basic ordering
        do_op(1, 0, 50);
        do_op(1, 0, 20);
        chk("m0.head20", int'(bus0.data_out), 20);
        chk("m0.cnt2", int'(bus0.count), 2);
        do_op(0, 1, 0);
        chk("m0.head50", int'(bus0.data_out), 50);
        chk("m0.cnt1", int'(bus0.count), 1);
        do_op(1, 0, 14);
        chk("m0.head14", int'(bus0.data_out), 14);
        do_op(0, 1, 0);
        chk("m0.back50a", int'(bus0.data_out), 50);
        do_op(1, 0, 24);
        chk("m0.head24", int'(bus0.data_out), 24);
        do_op(0, 1, 0);
        chk("m0.back50b", int'(bus0.data_out), 50);
        do_op(0, 1, 0);
        chk("m0.empty", int'(bus0.empty), 1);
        chk("m0.empty_out", int'(bus0.data_out), 0);

        // full boundary
        for (int i = 1; i <= 8; i++) do_op(1, 0, i);
        do_op(1, 0, 9);
        chk("full.ovf", int'(bus0.overflow), 1);
        chk("full.cnt", int'(bus0.count), 8);
        chk("full.head", int'(bus0.data_out), 1);
        do_op(0, 0, 0);
        chk("full.ovf_drop", int'(bus0.overflow), 0);
        do_op(1, 1, 0);
        chk("full.both_head", int'(bus0.data_out), 0);
        chk("full.both_cnt", int'(bus0.count), 8);

        // empty boundary
        do_reset();
        do_op(0, 1, 0);
        chk("emp.udf", int'(bus0.underflow), 1);
        chk("emp.cnt", int'(bus0.count), 0);
        do_op(1, 1, 7);
        chk("emp.both_udf", int'(bus0.underflow), 1);
        chk("emp.both_head", int'(bus0.data_out), 7);
        chk("emp.both_cnt", int'(bus0.count), 1);

        // max-first with ties
        do_reset();
        do_op(1, 0, 5);
        do_op(1, 0, 9);
        do_op(1, 0, 5);
        do_op(1, 0, 3);
        chk("m1.head9", int'(bus1.data_out), 9);
        do_op(0, 1, 0);
        chk("m1.head5a", int'(bus1.data_out), 5);
        do_op(0, 1, 0);
        chk("m1.head5b", int'(bus1.data_out), 5);
        do_op(0, 1, 0);
        chk("m1.head3", int'(bus1.data_out), 3);
        do_op(0, 1, 0);
        chk("m1.empty", int'(bus1.empty), 1);
        chk("m1.pops", pop1.size(), 4);
        if (pop1.size() == 4) begin
            chk("m1.pop0", pop1[0].val, 9);
            chk("m1.pop1", pop1[1].val, 5);
            chk("m1.pop2", pop1[2].val, 5);
            chk("m1.pop3", pop1[3].val, 3);
            chk("m1.fifo_tie",
                int'(pop1[1].tag < pop1[2].tag), 1);
        end

        // asynchronous reset between edges
        for (int i = 0; i < 4; i++) do_op(1, 0, 30 + i);
        chk("ar.cnt4", int'(bus0.count), 4);
        #1 rst = 1;
        #1;
        chk("ar.cnt", int'(bus0.count), 0);
        chk("ar.empty", int'(bus0.empty), 1);
        chk("ar.out", int'(bus0.data_out), 0);
        #1 rst = 0;
        do_op(1, 0, 42);
        chk("ar.head42", int'(bus0.data_out), 42);
        chk("ar.head42_m1", int'(bus1.data_out), 42);

        // randomized traffic: fill-biased then drain-biased
        for (int i = 0; i < 800; i++) begin
            int pe = (i < 400) ? 60 : 35;
            bit e = ($urandom_range(0, 99) < pe);
            bit d = ($urandom_range(0, 99) < 45);
            if (i % 250 == 249) do_reset();
            do_op(e, d, int'($urandom_range(0, 15)));
        end

        @(negedge clk);
        #1;
        checking = 0;
        $display("Result: errors=%0d of %0d checks",
                 n_err, n_checks);
        $finish;
    end

endmodule
